// File: rtl/rv_isa_defs.sv
// RV32I encoding constants and the symbolic-request-to-instruction-word encoder.
// The ALU control codes match the ones the core's ALU decoder produces.
package rv_isa_defs;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    CLS_MEM    = 2'b00,
    CLS_BRANCH = 2'b01,
    CLS_R      = 2'b10,
    CLS_I      = 2'b11
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [2:0]   alu;
    logic         store;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [11:0]  imm;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] word;
    logic        illegal;
  } enc_rsp_t;

  function automatic enc_rsp_t encode(enc_req_t r);
    enc_rsp_t   e;
    logic [2:0] f3;
    logic       alu_bad;
    e.word  = '0;
    e.illegal = 1'b0;
    f3      = F3_ADD_SUB;
    alu_bad = 1'b0;
    case (r.alu)
      ALU_ADD, ALU_SUB: f3 = F3_ADD_SUB;
      ALU_AND:          f3 = F3_AND;
      ALU_OR:           f3 = F3_OR;
      ALU_SLT:          f3 = F3_SLT;
      default:          alu_bad = 1'b1;
    endcase
    case (r.cls)
      CLS_MEM: begin
        if (r.store) e.word = {r.imm[11:5], r.rs2, r.rs1, F3_LW_SW, r.imm[4:0], OP_STORE};
        else         e.word = {r.imm, r.rs1, F3_LW_SW, r.rd, OP_LOAD};
      end
      // imm holds branch offset bits [12:1]: imm[11]=off[12], imm[10]=off[11]
      CLS_BRANCH: e.word = {r.imm[11], r.imm[9:4], r.rs2, r.rs1, F3_BEQ,
                            r.imm[3:0], r.imm[10], OP_BRANCH};
      CLS_R: begin
        e.word    = {(r.alu == ALU_SUB) ? F7_SUB : 7'b0, r.rs2, r.rs1, f3, r.rd, OP_R};
        e.illegal = alu_bad;
      end
      CLS_I: begin
        e.word    = {r.imm, r.rs1, f3, r.rd, OP_I};
        e.illegal = alu_bad | (r.alu == ALU_SUB);
      end
      default: e.word = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x 32 FIFO; full/empty come from an extra wrap bit on each pointer.
module instr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [31:0] data_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [31:0] data_o
);
  localparam int PW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        do_push, do_pop;

  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (PW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Encodes symbolic instruction requests into RV32I words, queues them, and streams
// them into instruction memory at consecutive word addresses.
module rv_instr_encoder
  import rv_isa_defs::*;
#(
  parameter int            DEPTH     = 4,
  parameter int            AW        = 10,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [1:0]    i_class,
  input  logic [2:0]    i_alu_ctrl,
  input  logic          i_store,
  input  logic [4:0]    i_rd,
  input  logic [4:0]    i_rs1,
  input  logic [4:0]    i_rs2,
  input  logic [11:0]   i_imm,
  output logic          o_wr_valid,
  input  logic          i_mem_ready,
  output logic [AW-1:0] o_wr_addr,
  output logic [31:0]   o_wr_data,
  output logic [AW-2:0] o_count,
  output logic          o_err
);
  enc_req_t      req;
  enc_rsp_t      rsp;
  logic          flush, accept, push, pop, full, empty;
  logic [31:0]   head;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-2:0] count_q, count_d;
  logic          err_q, err_d;

  assign flush = i_rst | i_clear;

  assign req = '{cls: instr_class_e'(i_class), alu: i_alu_ctrl, store: i_store,
                 rd: i_rd, rs1: i_rs1, rs2: i_rs2, imm: i_imm};
  assign rsp = encode(req);

  // Illegal requests still complete the handshake; they just never reach the FIFO.
  assign accept = i_valid & o_ready;
  assign push   = accept & ~rsp.illegal;
  assign pop    = o_wr_valid & i_mem_ready;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (flush),
    .push_i  (push),
    .data_i  (rsp.word),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .data_o  (head)
  );

  assign o_ready    = ~full;
  assign o_wr_valid = ~empty;
  assign o_wr_data  = empty ? 32'h0 : head;
  assign o_wr_addr  = addr_q;
  assign o_count    = count_q;
  assign o_err      = err_q;

  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q | (accept & rsp.illegal);
    if (pop) begin
      addr_d  = addr_q + AW'(4);
      count_d = count_q + (AW-1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (flush) begin
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: encodings, illegal requests, backpressure,
// reset/clear mid-stream and address wrap.
module tb_rv_instr_encoder;
  logic        clk = 1'b0;
  logic        rst, clr, valid, ready, store, wr_valid, mem_ready, err;
  logic [1:0]  cls;
  logic [2:0]  alu;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  count;

  int checks = 0;
  int errors = 0;

  rv_instr_encoder #(.DEPTH(4), .AW(10), .BASE_ADDR(10'd0)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(valid), .o_ready(ready),
    .i_class(cls), .i_alu_ctrl(alu), .i_store(store), .i_rd(rd), .i_rs1(rs1),
    .i_rs2(rs2), .i_imm(imm), .o_wr_valid(wr_valid), .i_mem_ready(mem_ready),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_count(count), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] c, input logic [2:0] a, input logic s,
                         input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [11:0] im);
    cls = c; alu = a; store = s; rd = d; rs1 = r1; rs2 = r2; imm = im;
  endtask

  task automatic push(input logic [1:0] c, input logic [2:0] a, input logic s,
                      input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [11:0] im);
    set_req(c, a, s, d, r1, r2, im);
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},    32'(ready),    32'd1);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, "_addr"},     32'(wr_addr),  32'd0);
    chk({tag, "_data"},     wr_data,       32'd0);
    chk({tag, "_count"},    32'(count),    32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; valid = 1'b0; mem_ready = 1'b0;
    set_req(2'b00, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
    step(); step();
    rst = 1'b0;
    chk_reset_state("reset");

    // R add then R sub, both queued before memory accepts
    push(2'b10, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("radd_valid", 32'(wr_valid), 32'd1);
    chk("radd_data",  wr_data, 32'h002081B3);
    chk("radd_addr",  32'(wr_addr), 32'd0);
    push(2'b10, 3'b001, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    mem_ready = 1'b1;
    step();
    chk("rsub_data",  wr_data, 32'h402081B3);
    chk("rsub_addr",  32'(wr_addr), 32'd4);
    chk("count1",     32'(count), 32'd1);
    step();
    chk("count2",     32'(count), 32'd2);
    chk("drain_valid", 32'(wr_valid), 32'd0);
    mem_ready = 1'b0;

    // lw, sw, beq
    push(2'b00, 3'b000, 1'b0, 5'd5, 5'd2, 5'd0, 12'd8);
    push(2'b00, 3'b000, 1'b1, 5'd0, 5'd2, 5'd5, 12'd12);
    push(2'b01, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 12'd4);
    chk("lw_data", wr_data, 32'h00812283);
    chk("lw_addr", 32'(wr_addr), 32'd8);
    mem_ready = 1'b1;
    step();
    chk("sw_data", wr_data, 32'h00512623);
    chk("sw_addr", 32'(wr_addr), 32'd12);
    step();
    chk("beq_data", wr_data, 32'h00208463);
    chk("beq_addr", 32'(wr_addr), 32'd16);
    step();
    chk("enc_count", 32'(count), 32'd5);
    chk("enc_empty", 32'(wr_valid), 32'd0);

    // illegal requests: handshake completes, nothing written, sticky error
    mem_ready = 1'b0;
    set_req(2'b11, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 12'd1);
    chk("ill_ready", 32'(ready), 32'd1);
    push(2'b11, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 12'd1);
    chk("isub_err",   32'(err), 32'd1);
    chk("isub_nowr",  32'(wr_valid), 32'd0);
    push(2'b10, 3'b111, 1'b0, 5'd1, 5'd1, 5'd2, 12'd0);
    step();
    chk("ctrl7_err",  32'(err), 32'd1);
    chk("ctrl7_nowr", 32'(wr_valid), 32'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_reset_state("clear_err");

    // backpressure: fill, no pass-through when full, then drain back to back
    for (int i = 0; i < 4; i++) push(2'b10, 3'b000, 1'b0, 5'(i), 5'd1, 5'd2, 12'd0);
    chk("full_ready", 32'(ready), 32'd0);
    chk("full_head",  wr_data, 32'h00208033);
    step();
    chk("full_stable", wr_data, 32'h00208033);
    chk("full_addr",   32'(wr_addr), 32'd0);
    set_req(2'b10, 3'b000, 1'b0, 5'd9, 5'd1, 5'd2, 12'd0);
    valid = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("full_pop_ready", 32'(ready), 32'd0);
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_addr", i), 32'(wr_addr), 32'(4 * i));
      chk($sformatf("drain%0d_data", i), wr_data, 32'h00208033 | 32'(i << 7));
      step();
    end
    chk("drain_done", 32'(wr_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd4);

    // reset with FIFO half full and a request in flight
    mem_ready = 1'b0;
    push(2'b10, 3'b000, 1'b0, 5'd1, 5'd1, 5'd2, 12'd0);
    push(2'b10, 3'b000, 1'b0, 5'd2, 5'd1, 5'd2, 12'd0);
    rst = 1'b1; valid = 1'b1;
    step();
    rst = 1'b0; valid = 1'b0;
    chk_reset_state("midrst");
    push(2'b00, 3'b000, 1'b0, 5'd5, 5'd2, 5'd0, 12'd8);
    chk("midrst_data", wr_data, 32'h00812283);
    chk("midrst_addr", 32'(wr_addr), 32'd0);
    mem_ready = 1'b1;
    step();
    chk("midrst_count", 32'(count), 32'd1);

    // same with clear
    mem_ready = 1'b0;
    push(2'b10, 3'b000, 1'b0, 5'd1, 5'd1, 5'd2, 12'd0);
    push(2'b10, 3'b000, 1'b0, 5'd2, 5'd1, 5'd2, 12'd0);
    clr = 1'b1; valid = 1'b1;
    step();
    clr = 1'b0; valid = 1'b0;
    chk_reset_state("midclr");
    push(2'b00, 3'b000, 1'b1, 5'd0, 5'd2, 5'd5, 12'd12);
    chk("midclr_data", wr_data, 32'h00512623);
    chk("midclr_addr", 32'(wr_addr), 32'd0);

    // address wrap: 255 more writes reach 1020, next goes to 0
    mem_ready = 1'b1;
    step();
    for (int i = 0; i < 254; i++) begin
      push(2'b10, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
      step();
    end
    chk("wrap_pre_addr",  32'(wr_addr), 32'd1020);
    chk("wrap_pre_count", 32'(count), 32'd255);
    push(2'b10, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    chk("wrap_head_addr", 32'(wr_addr), 32'd1020);
    step();
    chk("wrap_addr",  32'(wr_addr), 32'd0);
    chk("wrap_count", 32'(count), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
